// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared VGA timing definitions. The timing generator, the icon block and the
// colorizer all import this package, so they agree on the default 640x480
// mode, on how the frame totals are derived and on where the sync windows lie.
// The package has no ports: it holds constants, helper functions and the
// bundle type for the registered control outputs.
// ----------------------------------------------------------------------------
package vga_pkg;

  // Width of the pixel/line counters. 10 bits covers H_TOTAL=800 and V_TOTAL=525.
  localparam int unsigned CNT_W = 10;

  // Default 640x480 @ 60 Hz timing (25 MHz pixel rate from a 100 MHz clk).
  localparam int unsigned CLK_DIV_DEF  = 4;
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  // Total span of one axis (pixels per line or lines per frame).
  function automatic int unsigned span_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // First count inside the sync pulse.
  function automatic int unsigned sync_start(input int unsigned active,
                                             input int unsigned fp);
    return active + fp;
  endfunction

  // First count after the sync pulse (exclusive bound).
  function automatic int unsigned sync_end(input int unsigned active,
                                           input int unsigned fp,
                                           input int unsigned sync);
    return active + fp + sync;
  endfunction

  localparam int unsigned H_TOTAL_DEF =
    span_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int unsigned V_TOTAL_DEF =
    span_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  // Registered control outputs, kept together so they share one next-state
  // computation and one reset value.
  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic video_on;
    logic pix_tick;
    logic frame_tick;
  } vga_ctrl_t;

  localparam vga_ctrl_t CTRL_RESET = '{
    hsync_n:    1'b1,
    vsync_n:    1'b1,
    video_on:   1'b0,
    pix_tick:   1'b0,
    frame_tick: 1'b0
  };

endpackage

// File: rtl/clk_en_div.sv
// ----------------------------------------------------------------------------
// clk_en_div
// Pixel-rate enable generator. Counts clk cycles 0..CLK_DIV-1 and raises
// 'advance' combinationally during the last cycle of each pixel period, so
// the consumer steps exactly once every CLK_DIV clocks. With CLK_DIV=1 the
// counter is held at zero and 'advance' is permanently high.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset (counter returns to 0)
//   advance  out  high in the cycle whose rising edge ends a pixel period
// ----------------------------------------------------------------------------
module clk_en_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic advance
);

  // A one-bit counter is still kept for CLK_DIV=1 so the port list and the
  // comparison stay uniform; it simply never leaves zero.
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  assign advance = (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = advance ? '0 : div_cnt_q + 1'b1;
  end

  // NOTE: sequential state is only ever updated with non-blocking '<=' so all
  // registers sample their next value from the same pre-edge snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing generator. A clk_en_div instance produces one 'advance'
// per pixel period; on each advance the horizontal count steps and, at the
// end of a line, the vertical count steps. Sync, video-enable and tick
// outputs are decoded from the *next* counts and registered on the same edge
// as the counts, so every output changes in the same cycle as pixCol/pixRow
// and none of them lags.
//
// Ports
//   clk        in   system clock, rising edge (only clock in the block)
//   rst_n      in   asynchronous active-low reset (release synchronised
//                   upstream by the system reset bridge)
//   pixCol     out  current pixel count, 0..H_TOTAL-1
//   pixRow     out  current line count, 0..V_TOTAL-1
//   hSync      out  horizontal sync, active low
//   vSync      out  vertical sync, active low
//   videoOn    out  high while (pixCol,pixRow) is in the active region
//   pixTick    out  one-clk pulse in the first clk of each new pixel
//   frameTick  out  one-clk pulse in the first clk of pixel (0,0)
//
// While in reset the counts sit at (H_TOTAL-1, V_TOTAL-1), so the first
// advance after release wraps both of them and presents (0,0) with
// frameTick set, CLK_DIV clocks after release.
// ----------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] pixCol,
  output logic [CNT_W-1:0] pixRow,
  output logic             hSync,
  output logic             vSync,
  output logic             videoOn,
  output logic             pixTick,
  output logic             frameTick
);

  localparam int unsigned H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // All decode bounds are full counter-width constants so every comparison
  // is done on the complete 10-bit count.
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START  = CNT_W'(sync_start(H_ACTIVE, H_FP));
  localparam logic [CNT_W-1:0] HS_END    = CNT_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [CNT_W-1:0] VS_START  = CNT_W'(sync_start(V_ACTIVE, V_FP));
  localparam logic [CNT_W-1:0] VS_END    = CNT_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));

  logic             advance;
  logic [CNT_W-1:0] h_count_q, h_count_d;
  logic [CNT_W-1:0] v_count_q, v_count_d;
  vga_ctrl_t        ctrl_q, ctrl_d;

  clk_en_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_en_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (advance)
  );

  // Raster counters: horizontal steps on advance, vertical steps (and both
  // wrap) on the same edge that ends the line.
  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    if (advance) begin
      if (h_count_q == H_LAST) begin
        h_count_d = '0;
        v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + 1'b1;
      end else begin
        h_count_d = h_count_q + 1'b1;
      end
    end
  end

  // Decode from the next counts so the registered outputs line up with the
  // registered counts rather than trailing them by a cycle.
  always_comb begin
    ctrl_d            = CTRL_RESET;
    ctrl_d.hsync_n    = !((h_count_d >= HS_START) && (h_count_d < HS_END));
    ctrl_d.vsync_n    = !((v_count_d >= VS_START) && (v_count_d < VS_END));
    ctrl_d.video_on   = (h_count_d < H_ACT_END) && (v_count_d < V_ACT_END);
    ctrl_d.pix_tick   = advance;
    ctrl_d.frame_tick = advance && (h_count_d == '0) && (v_count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count_q <= H_LAST;
      v_count_q <= V_LAST;
      ctrl_q    <= CTRL_RESET;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign pixCol    = h_count_q;
  assign pixRow    = v_count_q;
  assign hSync     = ctrl_q.hsync_n;
  assign vSync     = ctrl_q.vsync_n;
  assign videoOn   = ctrl_q.video_on;
  assign pixTick   = ctrl_q.pix_tick;
  assign frameTick = ctrl_q.frame_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
// Two instances share clk and rst_n: 'a' uses the default 640x480 timing with
// CLK_DIV=4, 'b' uses a miniature 15x11 raster with CLK_DIV=1 so whole frames
// fit in a short run. A reference model predicts every output from the number
// of rising edges seen since reset release; predictions are queued at the
// driving edge and compared on the following falling edge.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

  typedef struct {
    int col;
    int row;
    bit hs;
    bit vs;
    bit von;
    bit tick;
    bit frame;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [9:0] a_col, a_row, b_col, b_row;
  logic       a_hs, a_vs, a_von, a_tick, a_ft;
  logic       b_hs, b_vs, b_von, b_tick, b_ft;

  int n_checks = 0;
  int n_errors = 0;

  int   n_a = 0;
  int   n_b = 0;
  exp_t sb_q[$];
  bit   track = 1'b0;

  // Scenario tracking state.
  bit a_first_seen = 0, a_hs_prev = 1, a_hs_on = 0, a_hs_start_seen = 0, a_line_have = 0;
  int a_hs_cnt = 0, a_line_ticks = 0;
  bit b_first_seen = 0, b_hs_prev = 1, b_have = 0;
  int b_hs_cnt = 0, b_vs_cnt = 0, b_last_ft = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .pixCol    (a_col),
    .pixRow    (a_row),
    .hSync     (a_hs),
    .vSync     (a_vs),
    .videoOn   (a_von),
    .pixTick   (a_tick),
    .frameTick (a_ft)
  );

  vga_timing_gen #(
    .CLK_DIV  (1),
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (2)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .pixCol    (b_col),
    .pixRow    (b_row),
    .hSync     (b_hs),
    .vSync     (b_vs),
    .videoOn   (b_von),
    .pixTick   (b_tick),
    .frameTick (b_ft)
  );

  task automatic check(input string tag, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp_v, $time);
    end
  endtask

  // Expected outputs after n rising edges with reset released. The first
  // pixel appears after cd edges; before that the reset values are held.
  function automatic exp_t model(input int n, input int cd,
                                 input int ha, input int hf, input int hsy, input int hb,
                                 input int va, input int vf, input int vsy, input int vb);
    exp_t e;
    int   ht, vt, lin;
    ht = ha + hf + hsy + hb;
    vt = va + vf + vsy + vb;
    if (n < cd) begin
      e.col = ht - 1; e.row = vt - 1;
      e.hs = 1; e.vs = 1; e.von = 0; e.tick = 0; e.frame = 0;
    end else begin
      lin    = n / cd - 1;
      e.col  = lin % ht;
      e.row  = (lin / ht) % vt;
      e.tick = (n % cd) == 0;
      e.hs   = !(e.col >= ha + hf && e.col < ha + hf + hsy);
      e.vs   = !(e.row >= va + vf && e.row < va + vf + vsy);
      e.von  = (e.col < ha) && (e.row < va);
      e.frame = e.tick && e.col == 0 && e.row == 0;
    end
    return e;
  endfunction

  task automatic cmp_out(input string who, input exp_t e,
                         input logic [9:0] col, input logic [9:0] row,
                         input logic hs, input logic vs, input logic von,
                         input logic tick, input logic ft);
    check({who, ".pixCol"},    int'(col),  e.col);
    check({who, ".pixRow"},    int'(row),  e.row);
    check({who, ".hSync"},     int'(hs),   int'(e.hs));
    check({who, ".vSync"},     int'(vs),   int'(e.vs));
    check({who, ".videoOn"},   int'(von),  int'(e.von));
    check({who, ".pixTick"},   int'(tick), int'(e.tick));
    check({who, ".frameTick"}, int'(ft),   int'(e.frame));
  endtask

  task automatic observe();
    // a: first frame after release
    if (a_ft && !a_first_seen) begin
      check("a_first_frame_clks", n_a, 4);
      check("a_first_videoOn", int'(a_von), 1);
      a_first_seen = 1;
    end
    // a: horizontal sync window length and position
    if (!a_hs && a_hs_prev) begin
      a_hs_cnt = 0;
      a_hs_on  = 1;
      if (!a_hs_start_seen) begin
        check("a_hsync_start_col", int'(a_col), 656);
        a_hs_start_seen = 1;
      end
    end
    if (!a_hs) a_hs_cnt++;
    if (a_hs && !a_hs_prev && a_hs_on) begin
      check("a_hsync_clks", a_hs_cnt, 384);
      a_hs_on = 0;
    end
    a_hs_prev = a_hs;
    // a: pixTicks per line
    if (a_tick) a_line_ticks++;
    if (a_tick && a_col == 10'd0) begin
      if (a_line_have) check("a_line_ticks", a_line_ticks, 800);
      a_line_ticks = 0;
      a_line_have  = 1;
    end

    // b: first frame, sync windows in pixel counts, frame period
    if (b_ft && !b_first_seen) begin
      check("b_first_frame_clks", n_b, 1);
      b_first_seen = 1;
    end
    if (b_tick && !b_hs) b_hs_cnt++;
    if (b_hs && !b_hs_prev) begin
      check("b_hsync_ticks", b_hs_cnt, 3);
      b_hs_cnt = 0;
    end
    b_hs_prev = b_hs;
    if (b_tick && !b_vs) b_vs_cnt++;
    if (b_ft) begin
      if (b_have) begin
        check("b_frame_clks", n_b - b_last_ft, 165);
        check("b_vsync_ticks", b_vs_cnt, 30);
      end
      b_have    = 1;
      b_last_ft = n_b;
      b_vs_cnt  = 0;
    end
  endtask

  // One clock: predict at the rising edge, compare at the falling edge.
  task automatic step();
    exp_t e;
    @(posedge clk);
    if (rst_n) begin
      n_a++;
      n_b++;
    end
    sb_q.push_back(model(n_a, 4, 640, 16, 96, 48, 480, 10, 2, 33));
    sb_q.push_back(model(n_b, 1, 8, 2, 3, 2, 6, 1, 2, 2));
    @(negedge clk);
    e = sb_q.pop_front();
    cmp_out("a", e, a_col, a_row, a_hs, a_vs, a_von, a_tick, a_ft);
    e = sb_q.pop_front();
    cmp_out("b", e, b_col, b_row, b_hs, b_vs, b_von, b_tick, b_ft);
    if (track) observe();
  endtask

  initial begin
    int found;

    // Reset held across several edges.
    rst_n = 1'b0;
    repeat (3) step();

    // Release between edges and run a little over two default lines.
    rst_n = 1'b1;
    track = 1'b1;
    repeat (7000) step();
    track = 1'b0;

    // Bounded wait for a mid-frame position on the miniature raster.
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      step();
      if (b_col == 10'd5 && b_row == 10'd4) found = 1;
    end
    check("b_reach_mid", found, 1);

    // Asynchronous reset between edges: outputs must change before any clk.
    #2;
    rst_n = 1'b0;
    n_a   = 0;
    n_b   = 0;
    #1;
    check("a_async_pixCol",    int'(a_col),  799);
    check("a_async_pixRow",    int'(a_row),  524);
    check("a_async_hSync",     int'(a_hs),   1);
    check("a_async_vSync",     int'(a_vs),   1);
    check("a_async_videoOn",   int'(a_von),  0);
    check("a_async_pixTick",   int'(a_tick), 0);
    check("a_async_frameTick", int'(a_ft),   0);
    check("b_async_pixCol",    int'(b_col),  14);
    check("b_async_pixRow",    int'(b_row),  10);
    check("b_async_hSync",     int'(b_hs),   1);
    check("b_async_videoOn",   int'(b_von),  0);
    check("b_async_pixTick",   int'(b_tick), 0);

    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("b_restart_frameTick", int'(b_ft), 1);
    repeat (200) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
